// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-mode controller gating the CPU clock enable (step, run-N, free-run)
module cpu_run_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int NUM_BP = 2
) (
    input  logic                     Clk,
    input  logic                     Clrn,
    input  logic [1:0]               Mode,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic [CNT_W-1:0]         Run_count,
    input  logic [NUM_BP*ADDR_W-1:0] Bp_addr,
    input  logic [NUM_BP-1:0]        Bp_en,
    input  logic [ADDR_W-1:0]        Iaddr,
    input  logic                     Clr_cnt,
    output logic                     Cpu_ce,
    output logic                     Busy,
    output logic                     Done,
    output logic [1:0]               Halt_cause,
    output logic [NUM_BP-1:0]        Bp_hit,
    output logic [31:0]              Instr_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUNN = 2'b10;
    localparam logic [1:0] MODE_FREE = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_COUNT = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_STOP  = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               first_q, first_d;
    logic [1:0]         cause_q, cause_d;
    logic [NUM_BP-1:0]  bp_hit_q, bp_hit_d;
    logic [31:0]        instr_cnt_q, instr_cnt_d;

    logic [NUM_BP-1:0]  bp_vec;
    logic               bp_match;
    logic               run_ce;

    // first_q masks the match so a run can resume from the PC it halted on
    always_comb begin
        bp_vec = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_vec[i] = Bp_en[i] && (Iaddr == Bp_addr[i*ADDR_W +: ADDR_W]);
        end
        bp_match = (|bp_vec) && !first_q;
        run_ce   = (state_q == S_RUN) && !Stop && !bp_match;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            remaining_q <= '0;
            first_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
            bp_hit_q    <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            cause_q     <= cause_d;
            bp_hit_q    <= bp_hit_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        cause_d     = cause_q;
        bp_hit_d    = bp_hit_q;
        case (state_q)
            S_IDLE: begin
                if (Start && (Mode != 2'b00)) begin
                    mode_d   = Mode;
                    first_d  = 1'b1;
                    cause_d  = CAUSE_NONE;
                    bp_hit_d = '0;
                    if (Mode == MODE_STEP) begin
                        remaining_d = CNT_W'(1);
                        state_d     = S_RUN;
                    end else if (Mode == MODE_RUNN) begin
                        if (Run_count != '0) begin
                            remaining_d = Run_count;
                            state_d     = S_RUN;
                        end else begin
                            cause_d = CAUSE_COUNT;
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                first_d = 1'b0;
                if (Stop) begin
                    cause_d = CAUSE_STOP;
                    state_d = S_DONE;
                end else if (bp_match) begin
                    cause_d  = CAUSE_BP;
                    bp_hit_d = bp_vec;
                    state_d  = S_DONE;
                end else if (mode_q != MODE_FREE) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        cause_d = CAUSE_COUNT;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Clear beats a coincident retire
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if (Clr_cnt) begin
            instr_cnt_d = '0;
        end else if (run_ce) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_comb begin
        Cpu_ce     = run_ce;
        Busy       = (state_q != S_IDLE);
        Done       = (state_q == S_DONE);
        Halt_cause = cause_q;
        Bp_hit     = bp_hit_q;
        Instr_cnt  = instr_cnt_q;
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl run modes, breakpoints, stop, reset
module tb_cpu_run_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int NUM_BP = 2;

    logic                     clk = 1'b0;
    logic                     clrn = 1'b0;
    logic [1:0]               mode = 2'b00;
    logic                     start = 1'b0;
    logic                     stop = 1'b0;
    logic [CNT_W-1:0]         run_count = '0;
    logic [NUM_BP*ADDR_W-1:0] bp_addr = '0;
    logic [NUM_BP-1:0]        bp_en = '0;
    logic [ADDR_W-1:0]        pc;
    logic                     clr_cnt = 1'b0;
    logic                     pc_clr = 1'b0;

    logic                     cpu_ce;
    logic                     busy;
    logic                     done;
    logic [1:0]               halt_cause;
    logic [NUM_BP-1:0]        bp_hit;
    logic [31:0]              instr_cnt;

    cpu_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) dut (
        .Clk        (clk),
        .Clrn       (clrn),
        .Mode       (mode),
        .Start      (start),
        .Stop       (stop),
        .Run_count  (run_count),
        .Bp_addr    (bp_addr),
        .Bp_en      (bp_en),
        .Iaddr      (pc),
        .Clr_cnt    (clr_cnt),
        .Cpu_ce     (cpu_ce),
        .Busy       (busy),
        .Done       (done),
        .Halt_cause (halt_cause),
        .Bp_hit     (bp_hit),
        .Instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in CPU: PC advances by 4 on every enabled cycle
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (cpu_ce) pc <= pc + 32'd4;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]        cause;
        logic [NUM_BP-1:0] bp;
        logic [31:0]       cnt;
        int                n_ce;
        int                lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_cnt = '0;

    task automatic issue(input logic [1:0] m, input logic [CNT_W-1:0] rc, input logic [1:0] cause,
                         input logic [NUM_BP-1:0] bp, input int n_ce, input int lat, input bit clr);
        exp_t e;
        model_cnt = clr ? 32'd0 : model_cnt + 32'(n_ce);
        e.cause = cause;
        e.bp    = bp;
        e.cnt   = model_cnt;
        e.n_ce  = n_ce;
        e.lat   = lat;
        sb.push_back(e);
        @(negedge clk);
        mode = m;
        run_count = rc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input string tag, input int stop_at, input int clr_at);
        int   k = 0;
        int   n = 0;
        bit   seen = 1'b0;
        bit   gap = 1'b0;
        bit   ended = 1'b0;
        exp_t e;
        while (k < 400 && !seen) begin
            k++;
            stop = (k == stop_at);
            clr_cnt = (k == clr_at);
            #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (k == stop_at) chk({tag, "_stop_ce"}, 32'(cpu_ce), 32'd0);
                if (cpu_ce) begin
                    if (ended) gap = 1'b1;
                    n++;
                end else begin
                    ended = 1'b1;
                end
            end
            @(negedge clk);
            stop = 1'b0;
            clr_cnt = 1'b0;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                chk({tag, "_n_ce"}, 32'(n), 32'(e.n_ce));
                chk({tag, "_contig"}, 32'(gap), 32'd0);
                chk({tag, "_latency"}, 32'(k), 32'(e.lat));
                chk({tag, "_cause"}, 32'(halt_cause), 32'(e.cause));
                chk({tag, "_bp_hit"}, 32'(bp_hit), 32'(e.bp));
                chk({tag, "_instr_cnt"}, instr_cnt, e.cnt);
                chk({tag, "_done_pulse"}, 32'(done), 32'd0);
                chk({tag, "_idle"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        // Reset and reset values
        pc_clr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        clrn = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;

        // Mode 00 start is ignored
        mode = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("mode00_busy", 32'(busy), 32'd0);

        // 1: single step
        issue(2'b01, '0, 2'b01, 2'b00, 1, 2, 1'b0);
        collect("t1_step", 0, 0);

        // 2: run-N 20 and run-N 0
        issue(2'b10, 16'd20, 2'b01, 2'b00, 20, 21, 1'b0);
        collect("t2_run20", 0, 0);
        issue(2'b10, 16'd0, 2'b01, 2'b00, 0, 1, 1'b0);
        collect("t2_run0", 0, 0);

        // 3: breakpoint on slot 1, then step past it
        bp_addr[1*ADDR_W +: ADDR_W] = 32'h0000_001C;
        bp_addr[0 +: ADDR_W] = 32'h0000_0100;
        bp_en = 2'b10;
        @(negedge clk);
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
        issue(2'b11, '0, 2'b10, 2'b10, 7, 9, 1'b0);
        collect("t3_bp", 0, 0);
        chk("t3_halt_pc", pc, 32'h0000_001C);
        issue(2'b01, '0, 2'b01, 2'b00, 1, 2, 1'b0);
        collect("t3_resume", 0, 0);
        chk("t3_resume_pc", pc, 32'h0000_0020);
        bp_en = 2'b00;

        // 4: free-run with stop on the 5th RUN cycle
        issue(2'b11, '0, 2'b11, 2'b00, 4, 6, 1'b0);
        collect("t4_stop", 5, 0);

        // 5: reset mid-run on the 10th RUN cycle, with an ignored Start earlier
        @(negedge clk);
        mode = 2'b10;
        run_count = 16'd100;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3);
            mode = (k == 3) ? 2'b01 : 2'b10;
            if (k == 10) begin
                #2 clrn = 1'b0;
                #1;
                chk("t5_async_ce", 32'(cpu_ce), 32'd0);
                chk("t5_busy", 32'(busy), 32'd0);
                chk("t5_done", 32'(done), 32'd0);
                chk("t5_cause", 32'(halt_cause), 32'd0);
                chk("t5_bp_hit", 32'(bp_hit), 32'd0);
                chk("t5_cnt", instr_cnt, 32'd0);
            end else if (k == 9) begin
                #1;
                chk("t5_still_running", 32'(cpu_ce), 32'd1);
                chk("t5_cnt_mid", instr_cnt, model_cnt + 32'd8);
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        model_cnt = 32'd0;
        @(negedge clk);
        #1;
        chk("t5_post_busy", 32'(busy), 32'd0);

        // 6: wrap of the instruction counter, then clear coinciding with a retire
        @(negedge clk);
        force dut.instr_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.instr_cnt_q;
        model_cnt = 32'hFFFF_FFFE;
        #1;
        chk("t6_preload", instr_cnt, 32'hFFFF_FFFE);
        issue(2'b10, 16'd3, 2'b01, 2'b00, 3, 4, 1'b0);
        collect("t6_wrap", 0, 0);
        issue(2'b01, '0, 2'b01, 2'b00, 1, 2, 1'b1);
        collect("t6_clr", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
